// File: rtl/bfxp_pipe.sv
// bfxp_pipe: pipelined bit-field extract-and-place unit.
// A field of len bits is pulled out of rs1 at bit start and deposited at bit
// dest of the result. The upper bits of the result are then zero-filled,
// sign-filled, or merged with rs2, depending on mode.
// Ops flow through 1..3 register stages with valid/ready flow control, and
// each op carries an opaque tag.
module bfxp_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int TAGW   = 4,
  localparam int LW    = $clog2(XLEN)
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      mode,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [LW-1:0]   start,
  input  logic [LW:0]     len,
  input  logic [LW-1:0]   dest,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd,
  output logic            out_err,
  output logic [TAGW-1:0] out_tag
);

  localparam logic [LW:0]     LMAX      = (LW+1)'(XLEN);
  localparam logic [LW+1:0]   IDX_LIMIT = (LW+2)'(XLEN);
  localparam logic [XLEN-1:0] ONE       = XLEN'(1);

  // Extract-side signals (computed straight from the inputs)
  logic [LW:0]     exLen;
  logic [XLEN-1:0] exMask;
  logic [XLEN-1:0] exField;
  logic [LW+1:0]   exSignIdx;
  logic            exSign;

  // Place-side operands (either the raw extract or the stage-1 registers)
  logic            plValid;
  logic [XLEN-1:0] plField;
  logic            plSign;
  logic [LW:0]     plLen;
  logic [LW-1:0]   plDest;
  logic [1:0]      plMode;
  logic [XLEN-1:0] plRs2;
  logic [TAGW-1:0] plTag;

  logic [XLEN-1:0] plMask;
  logic [XLEN-1:0] plPlaced;
  logic [XLEN-1:0] plHole;
  logic [LW+1:0]   plTop;
  logic [XLEN-1:0] plLow;
  logic [XLEN-1:0] plFill;

  // Result stage
  logic [XLEN-1:0] rRd_d;
  logic            rErr_d;
  logic            rValid_q;
  logic [XLEN-1:0] rRd_q;
  logic            rErr_q;
  logic [TAGW-1:0] rTag_q;
  logic            rReady;
  logic            rDownReady;

  // The extract stage does the following:
  // - clamps the length;
  // - shifts the field down and masks it;
  // - captures the sign bit, reading it as 0 when it lies past the top of rs1.
  always_comb begin
    exLen     = (len > LMAX) ? LMAX : len;
    exMask    = (exLen == LMAX) ? '1 : ((ONE << exLen) - ONE);
    exField   = (rs1 >> start) & exMask;
    exSignIdx = {2'b00, start} + {1'b0, exLen} - (LW+2)'(1);
    exSign    = 1'b0;
    if ((exLen != '0) && (exSignIdx < IDX_LIMIT)) begin
      exSign = rs1[exSignIdx[LW-1:0]];
    end
  end

  // Place the field at dest and apply the selected fill/merge policy.
  always_comb begin
    plMask   = (plLen == LMAX) ? '1 : ((ONE << plLen) - ONE);
    plPlaced = plField << plDest;
    plHole   = plMask << plDest;
    plTop    = {2'b00, plDest} + {1'b0, plLen};
    plLow    = (plTop >= IDX_LIMIT) ? '1 : ((ONE << plTop) - ONE);
    plFill   = plSign ? ~plLow : '0;
    rRd_d    = '0;
    rErr_d   = 1'b0;
    case (plMode)
      2'd0:    rRd_d = plPlaced;
      2'd1:    rRd_d = (plLen == '0) ? '0 : (plPlaced | plFill);
      2'd2:    rRd_d = (plRs2 & ~plHole) | plPlaced;
      default: rErr_d = 1'b1;
    endcase
  end

  assign rReady = !rValid_q || rDownReady;

  generate
    if (STAGES >= 2) begin : g_split
      logic            aValid_q;
      logic [XLEN-1:0] aField_q;
      logic            aSign_q;
      logic [LW:0]     aLen_q;
      logic [LW-1:0]   aDest_q;
      logic [1:0]      aMode_q;
      logic [XLEN-1:0] aRs2_q;
      logic [TAGW-1:0] aTag_q;
      logic            aReady;

      assign aReady   = !aValid_q || rReady;
      assign in_ready = aReady;

      // Stage 1 holds the extracted field and sign so the place/merge logic
      // sees registered operands.
      always_ff @(posedge clock) begin
        if (!resetn) begin
          aValid_q <= 1'b0;
          aField_q <= '0;
          aSign_q  <= 1'b0;
          aLen_q   <= '0;
          aDest_q  <= '0;
          aMode_q  <= '0;
          aRs2_q   <= '0;
          aTag_q   <= '0;
        end else if (aReady) begin
          aValid_q <= in_valid;
          if (in_valid) begin
            aField_q <= exField;
            aSign_q  <= exSign;
            aLen_q   <= exLen;
            aDest_q  <= dest;
            aMode_q  <= mode;
            aRs2_q   <= rs2;
            aTag_q   <= in_tag;
          end
        end
      end

      assign plValid = aValid_q;
      assign plField = aField_q;
      assign plSign  = aSign_q;
      assign plLen   = aLen_q;
      assign plDest  = aDest_q;
      assign plMode  = aMode_q;
      assign plRs2   = aRs2_q;
      assign plTag   = aTag_q;
    end else begin : g_direct
      assign in_ready = rReady;
      assign plValid  = in_valid;
      assign plField  = exField;
      assign plSign   = exSign;
      assign plLen    = exLen;
      assign plDest   = dest;
      assign plMode   = mode;
      assign plRs2    = rs2;
      assign plTag    = in_tag;
    end
  endgenerate

  // Result register. Its payload only changes when a valid op loads, so the
  // payload holds still while the stage is stalled.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rValid_q <= 1'b0;
      rRd_q    <= '0;
      rErr_q   <= 1'b0;
      rTag_q   <= '0;
    end else if (rReady) begin
      rValid_q <= plValid;
      if (plValid) begin
        rRd_q  <= rRd_d;
        rErr_q <= rErr_d;
        rTag_q <= plTag;
      end
    end
  end

  generate
    if (STAGES >= 3) begin : g_outreg
      logic            oValid_q;
      logic [XLEN-1:0] oRd_q;
      logic            oErr_q;
      logic [TAGW-1:0] oTag_q;
      logic            oReady;

      assign oReady     = !oValid_q || out_ready;
      assign rDownReady = oReady;

      // An extra output register isolates the result from the merge logic.
      always_ff @(posedge clock) begin
        if (!resetn) begin
          oValid_q <= 1'b0;
          oRd_q    <= '0;
          oErr_q   <= 1'b0;
          oTag_q   <= '0;
        end else if (oReady) begin
          oValid_q <= rValid_q;
          if (rValid_q) begin
            oRd_q  <= rRd_q;
            oErr_q <= rErr_q;
            oTag_q <= rTag_q;
          end
        end
      end

      assign out_valid = oValid_q;
      assign rd        = oRd_q;
      assign out_err   = oErr_q;
      assign out_tag   = oTag_q;
    end else begin : g_noout
      assign rDownReady = out_ready;
      assign out_valid  = rValid_q;
      assign rd         = rRd_q;
      assign out_err    = rErr_q;
      assign out_tag    = rTag_q;
    end
  endgenerate

endmodule

// File: tb/tb_bfxp_pipe.sv
// Testbench for bfxp_pipe. It instantiates three configurations:
//   index 0: XLEN=32, STAGES=1
//   index 1: XLEN=32, STAGES=2
//   index 2: XLEN=64, STAGES=3
// Results are compared against a bit-level reference model and a queue of
// expected results.
module tb_bfxp_pipe;

  typedef struct {
    logic [63:0] rd;
    logic        err;
    logic [3:0]  tag;
  } expT;

  logic        clock;
  logic        rstN    [3];
  logic        inV     [3];
  logic        outRdy  [3];
  logic [1:0]  inMode  [3];
  logic [63:0] inRs1   [3];
  logic [63:0] inRs2   [3];
  logic [5:0]  inStart [3];
  logic [6:0]  inLen   [3];
  logic [5:0]  inDest  [3];
  logic [3:0]  inTag   [3];
  logic        inRdy   [3];
  logic        outV    [3];
  logic [63:0] outRd   [3];
  logic        outErr  [3];
  logic [3:0]  outTag  [3];
  logic [31:0] rd0;
  logic [31:0] rd1;
  logic [63:0] rd2;

  int errors = 0;
  int checks = 0;

  bfxp_pipe #(.XLEN(32), .STAGES(1), .TAGW(4)) dut1 (
    .clock(clock), .resetn(rstN[0]), .in_valid(inV[0]), .in_ready(inRdy[0]),
    .mode(inMode[0]), .rs1(inRs1[0][31:0]), .rs2(inRs2[0][31:0]),
    .start(inStart[0][4:0]), .len(inLen[0][5:0]), .dest(inDest[0][4:0]),
    .in_tag(inTag[0]), .out_valid(outV[0]), .out_ready(outRdy[0]),
    .rd(rd0), .out_err(outErr[0]), .out_tag(outTag[0]));

  bfxp_pipe #(.XLEN(32), .STAGES(2), .TAGW(4)) dut2 (
    .clock(clock), .resetn(rstN[1]), .in_valid(inV[1]), .in_ready(inRdy[1]),
    .mode(inMode[1]), .rs1(inRs1[1][31:0]), .rs2(inRs2[1][31:0]),
    .start(inStart[1][4:0]), .len(inLen[1][5:0]), .dest(inDest[1][4:0]),
    .in_tag(inTag[1]), .out_valid(outV[1]), .out_ready(outRdy[1]),
    .rd(rd1), .out_err(outErr[1]), .out_tag(outTag[1]));

  bfxp_pipe #(.XLEN(64), .STAGES(3), .TAGW(4)) dut3 (
    .clock(clock), .resetn(rstN[2]), .in_valid(inV[2]), .in_ready(inRdy[2]),
    .mode(inMode[2]), .rs1(inRs1[2]), .rs2(inRs2[2]),
    .start(inStart[2]), .len(inLen[2]), .dest(inDest[2]),
    .in_tag(inTag[2]), .out_valid(outV[2]), .out_ready(outRdy[2]),
    .rd(rd2), .out_err(outErr[2]), .out_tag(outTag[2]));

  assign outRd[0] = {32'd0, rd0};
  assign outRd[1] = {32'd0, rd1};
  assign outRd[2] = rd2;

  // Free-running clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop so a hung handshake can never stall the run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int xlOf(input int d);
    return (d == 2) ? 64 : 32;
  endfunction

  function automatic int stOf(input int d);
    return d + 1;
  endfunction

  // Reference model, built bit by bit from the field rules.
  function automatic logic [63:0] refRd(input int xl, input logic [1:0] md,
                                        input logic [63:0] a, input logic [63:0] b,
                                        input int st, input int ln, input int ds);
    int L;
    logic [63:0] r;
    logic s;
    L = (ln > xl) ? xl : ln;
    if (md == 2'd3) return 64'd0;
    r = (md == 2'd2) ? b : 64'd0;
    for (int k = 0; k < L; k++) begin
      if (ds + k < xl) r[ds + k] = (st + k < xl) ? a[st + k] : 1'b0;
    end
    if (md == 2'd1) begin
      if (L == 0) return 64'd0;
      s = (st + L - 1 < xl) ? a[st + L - 1] : 1'b0;
      for (int i = ds + L; i < xl; i++) r[i] = s;
    end
    for (int i = xl; i < 64; i++) r[i] = 1'b0;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int d, input logic [1:0] md, input logic [63:0] a,
                               input logic [63:0] b, input int st, input int ln,
                               input int ds, input logic [3:0] tg);
    inMode[d]  = md;
    inRs1[d]   = a;
    inRs2[d]   = b;
    inStart[d] = 6'(st);
    inLen[d]   = 7'(ln);
    inDest[d]  = 6'(ds);
    inTag[d]   = tg;
  endtask

  task automatic randomOp(input int d);
    int xl;
    int ln;
    logic [63:0] a;
    logic [63:0] b;
    xl = xlOf(d);
    a  = {$urandom, $urandom};
    b  = {$urandom, $urandom};
    if (xl == 32) begin
      a[63:32] = 32'd0;
      b[63:32] = 32'd0;
    end
    ln = ($urandom_range(3) == 0) ? int'($urandom_range(2 * xl - 1)) : int'($urandom_range(xl));
    applyStimulus(d, 2'($urandom_range(3)), a, b, int'($urandom_range(xl - 1)), ln,
                  int'($urandom_range(xl - 1)), 4'($urandom_range(15)));
  endtask

  function automatic expT modelOf(input int d);
    expT e;
    e.rd  = refRd(xlOf(d), inMode[d], inRs1[d], inRs2[d], int'(inStart[d]),
                  int'(inLen[d]), int'(inDest[d]));
    e.err = (inMode[d] == 2'd3);
    e.tag = inTag[d];
    return e;
  endfunction

  // Offer a single operation to an idle pipe, then check its latency and result.
  task automatic runDirected(input int d, input string name, input logic [1:0] md,
                             input logic [63:0] a, input logic [63:0] b, input int st,
                             input int ln, input int ds, input logic [3:0] tg,
                             input logic [63:0] expRd, input logic expErr);
    @(negedge clock);
    applyStimulus(d, md, a, b, st, ln, ds, tg);
    inV[d]    = 1'b1;
    outRdy[d] = 1'b1;
    #1 checkOutput({name, "/accept"}, 64'(inRdy[d]), 64'd1);
    @(posedge clock);
    @(negedge clock);
    inV[d] = 1'b0;
    #1;
    for (int k = 0; k < stOf(d) - 1; k++) begin
      checkOutput({name, "/early"}, 64'(outV[d]), 64'd0);
      @(negedge clock);
      #1;
    end
    checkOutput({name, "/valid"}, 64'(outV[d]), 64'd1);
    checkOutput({name, "/rd"}, outRd[d], expRd);
    checkOutput({name, "/err"}, 64'(outErr[d]), 64'(expErr));
    checkOutput({name, "/tag"}, 64'(outTag[d]), 64'(tg));
  endtask

  // Random traffic with random backpressure, scoreboarded in order.
  task automatic runStream(input int d, input int nOps, input int pIn, input int pOut);
    expT q[$];
    expT e;
    int sent = 0;
    int cyc = 0;
    bit holding = 0;
    bit stalled = 0;
    logic [63:0] hRd;
    logic [3:0] hTag;
    logic hErr;
    while ((sent < nOps || q.size() != 0) && cyc < nOps * 20 + 100) begin
      @(negedge clock);
      if (!holding && sent < nOps && $urandom_range(99) < pIn) begin
        randomOp(d);
        holding = 1;
      end
      inV[d]    = holding;
      outRdy[d] = (sent >= nOps) ? 1'b1 : ($urandom_range(99) < pOut);
      #1;
      if (stalled) begin
        checkOutput("hold/valid", 64'(outV[d]), 64'd1);
        checkOutput("hold/rd", outRd[d], hRd);
        checkOutput("hold/err", 64'(outErr[d]), 64'(hErr));
        checkOutput("hold/tag", 64'(outTag[d]), 64'(hTag));
      end
      if (outRdy[d]) checkOutput("ready-chain", 64'(inRdy[d]), 64'd1);
      if (outV[d] && outRdy[d]) begin
        if (q.size() == 0) begin
          checkOutput("extra-result", 64'(q.size()), 64'd1);
        end else begin
          e = q.pop_front();
          checkOutput("stream/rd", outRd[d], e.rd);
          checkOutput("stream/err", 64'(outErr[d]), 64'(e.err));
          checkOutput("stream/tag", 64'(outTag[d]), 64'(e.tag));
        end
      end
      stalled = outV[d] && !outRdy[d];
      hRd  = outRd[d];
      hErr = outErr[d];
      hTag = outTag[d];
      if (inV[d] && inRdy[d]) begin
        q.push_back(modelOf(d));
        sent++;
        holding = 0;
      end
      cyc++;
    end
    checkOutput("stream/sent", 64'(sent), 64'(nOps));
    checkOutput("stream/left", 64'(q.size()), 64'd0);
    if (pIn == 100 && pOut == 100) begin
      checkOutput("stream/throughput", 64'(cyc <= nOps + stOf(d) + 2), 64'd1);
    end
    @(negedge clock);
    inV[d] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 checkOutput("stream/no-extra", 64'(outV[d]), 64'd0);
      @(negedge clock);
    end
  endtask

  // Two-stage pipe: fill it under backpressure, then release the stall.
  task automatic runBackpressure();
    expT e [3];
    @(negedge clock);
    outRdy[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clock);
      applyStimulus(1, 2'(i), {32'd0, $urandom}, {32'd0, $urandom}, int'($urandom_range(31)),
                    int'($urandom_range(32)), int'($urandom_range(31)), 4'(i + 9));
      inV[1] = 1'b1;
      e[i] = modelOf(1);
      #1 checkOutput("bp/ready", 64'(inRdy[1]), (i < 2) ? 64'd1 : 64'd0);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      #1;
      checkOutput("bp/stall-ready", 64'(inRdy[1]), 64'd0);
      checkOutput("bp/stall-valid", 64'(outV[1]), 64'd1);
      checkOutput("bp/stall-rd", outRd[1], e[0].rd);
      checkOutput("bp/stall-tag", 64'(outTag[1]), 64'(e[0].tag));
    end
    @(negedge clock);
    outRdy[1] = 1'b1;
    #1 checkOutput("bp/resume-ready", 64'(inRdy[1]), 64'd1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(negedge clock);
        inV[1] = 1'b0;
        #1;
      end
      checkOutput("bp/out-valid", 64'(outV[1]), 64'd1);
      checkOutput("bp/out-rd", outRd[1], e[i].rd);
      checkOutput("bp/out-err", 64'(outErr[1]), 64'(e[i].err));
      checkOutput("bp/out-tag", 64'(outTag[1]), 64'(e[i].tag));
    end
    @(negedge clock);
    #1 checkOutput("bp/empty", 64'(outV[1]), 64'd0);
  endtask

  // Three-stage pipe: reset while two ops are in flight and a third is offered.
  task automatic runMidReset();
    @(negedge clock);
    outRdy[2] = 1'b1;
    randomOp(2);
    inV[2] = 1'b1;
    @(negedge clock);
    randomOp(2);
    @(negedge clock);
    randomOp(2);
    rstN[2] = 1'b0;
    @(negedge clock);
    rstN[2] = 1'b1;
    inV[2]  = 1'b0;
    #1;
    checkOutput("rst/valid", 64'(outV[2]), 64'd0);
    checkOutput("rst/rd", outRd[2], 64'd0);
    checkOutput("rst/err", 64'(outErr[2]), 64'd0);
    checkOutput("rst/tag", 64'(outTag[2]), 64'd0);
    checkOutput("rst/ready", 64'(inRdy[2]), 64'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      #1 checkOutput("rst/stale", 64'(outV[2]), 64'd0);
    end
    runDirected(2, "rst/fresh64", 2'd0, 64'h0123456789ABCDEF, 64'd0, 32, 32, 0, 4'hA,
                64'h0000000001234567, 1'b0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rstN[d]   = 1'b0;
      inV[d]    = 1'b0;
      outRdy[d] = 1'b0;
      applyStimulus(d, 2'd0, 64'd0, 64'd0, 0, 0, 0, 4'd0);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int d = 0; d < 3; d++) rstN[d] = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("reset%0d/valid", d), 64'(outV[d]), 64'd0);
      checkOutput($sformatf("reset%0d/rd", d), outRd[d], 64'd0);
      checkOutput($sformatf("reset%0d/err", d), 64'(outErr[d]), 64'd0);
      checkOutput($sformatf("reset%0d/tag", d), 64'(outTag[d]), 64'd0);
      checkOutput($sformatf("reset%0d/ready", d), 64'(inRdy[d]), 64'd1);
    end

    runDirected(0, "zfill", 2'd0, 64'hDEADBEEF, 64'd0, 8, 8, 16, 4'h5, 64'h00BE0000, 1'b0);
    runDirected(0, "sfill", 2'd1, 64'h000000F0, 64'd0, 4, 4, 8, 4'h6, 64'hFFFFFF00, 1'b0);
    runDirected(0, "merge", 2'd2, 64'd0, 64'hFFFFFFFF, 0, 8, 4, 4'h7, 64'hFFFFF00F, 1'b0);
    runDirected(0, "merge-len0", 2'd2, 64'd0, 64'hFFFFFFFF, 0, 0, 4, 4'h8, 64'hFFFFFFFF, 1'b0);
    runDirected(0, "top-edge", 2'd0, 64'hF0000000, 64'd0, 28, 8, 0, 4'h9, 64'h0000000F, 1'b0);
    runDirected(0, "full-len", 2'd0, 64'h13579BDF, 64'd0, 0, 32, 0, 4'hA, 64'h13579BDF, 1'b0);
    runDirected(0, "clip-dest", 2'd0, 64'h0000FFFF, 64'd0, 0, 16, 24, 4'hB, 64'hFF000000, 1'b0);
    runDirected(0, "illegal", 2'd3, 64'h12345678, 64'h9ABCDEF0, 4, 8, 2, 4'hC, 64'd0, 1'b1);
    runDirected(2, "x64", 2'd0, 64'h0123456789ABCDEF, 64'd0, 32, 32, 0, 4'h3,
                64'h0000000001234567, 1'b0);

    runBackpressure();

    for (int d = 0; d < 3; d++) begin
      runStream(d, 120, 70, 60);
      runStream(d, 40, 100, 100);
    end

    runMidReset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
